// File: rtl/spi_slave_ctrl_if.sv
// Signal bundle between the SPI slave front end (edge counter, pins) and the
// protocol controller. The slave modport is the controller's view.
interface spi_slave_ctrl_if #(
    parameter int unsigned RX_W = 10,
    parameter int unsigned TX_W = 8
);
    logic            ss_n;
    logic            mosi;
    logic [3:0]      edge_cnt;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic            miso;

    modport master (
        output ss_n,
        output mosi,
        output edge_cnt,
        output tx_data,
        output tx_valid,
        input  rx_data,
        input  rx_valid,
        input  miso
    );

    modport slave (
        input  ss_n,
        input  mosi,
        input  edge_cnt,
        input  tx_data,
        input  tx_valid,
        output rx_data,
        output rx_valid,
        output miso
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave protocol controller: decodes the command bit, deserialises the
// frame payload into rx_data, tracks the read-address/read-data pairing and
// serialises the read-back byte onto miso.
module spi_slave_ctrl #(
    parameter int unsigned RX_W = 10,
    parameter int unsigned TX_W = 8
) (
    input logic             clk,
    input logic             rst,
    spi_slave_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } t_state;

    // edge_cnt value carrying the last payload bit
    localparam logic [3:0] LAST_CNT = 4'(RX_W + 1);
    // tx counter value while the last data bit is on miso
    localparam logic [2:0] TX_LAST  = 3'(TX_W - 1);

    t_state          r_state;
    // Only RX_W-1 bits are stored; the final bit is taken straight from mosi.
    logic [RX_W-2:0] r_rx_shift;
    logic [RX_W-1:0] r_rx_data;
    logic            r_rx_valid;
    logic            r_rx_done;
    logic            r_rd_addr_seen;
    logic [TX_W-1:0] r_tx_shift;
    logic [2:0]      r_tx_cnt;
    logic            r_tx_busy;
    logic            r_tx_done;
    logic            r_miso;

    logic            w_rx_bit;
    logic            w_rx_last;
    logic            w_tx_accept;

    // Payload window and read-back acceptance qualifiers
    always_comb begin
        w_rx_bit    = (bus.edge_cnt >= 4'd2) && (bus.edge_cnt <= LAST_CNT);
        w_rx_last   = (bus.edge_cnt == LAST_CNT);
        w_tx_accept = (r_state == StReadData) && r_rx_done && !r_tx_busy && !r_tx_done &&
                      bus.tx_valid;
    end

    // Frame sequencing, receive shift, transmit shift and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_rx_shift     <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_done      <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_tx_shift     <= '0;
            r_tx_cnt       <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b0;
            r_miso         <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_miso    <= 1'b0;
                    r_rx_done <= 1'b0;
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b0;
                    r_tx_cnt  <= '0;
                    if (!bus.ss_n) begin
                        r_state <= StChkCmd;
                    end
                end

                StChkCmd: begin
                    if (bus.ss_n) begin
                        r_state <= StIdle;
                    end else if (bus.edge_cnt == 4'd1) begin
                        if (!bus.mosi) begin
                            r_state <= StWrite;
                        end else if (r_rd_addr_seen) begin
                            r_state <= StReadData;
                        end else begin
                            r_state <= StReadAdd;
                        end
                    end
                end

                StWrite, StReadAdd, StReadData: begin
                    if (bus.ss_n) begin
                        // Abort; a transmit finishing on this very edge still counts.
                        r_state   <= StIdle;
                        r_miso    <= 1'b0;
                        r_tx_busy <= 1'b0;
                        if (r_tx_busy && (r_tx_cnt == TX_LAST)) begin
                            r_rd_addr_seen <= 1'b0;
                        end
                    end else if (!r_rx_done) begin
                        if (w_rx_bit && !w_rx_last) begin
                            r_rx_shift <= {r_rx_shift[RX_W-3:0], bus.mosi};
                        end
                        if (w_rx_last) begin
                            r_rx_data  <= {r_rx_shift, bus.mosi};
                            r_rx_valid <= 1'b1;
                            r_rx_done  <= 1'b1;
                            if (r_state == StReadAdd) begin
                                r_rd_addr_seen <= 1'b1;
                            end
                        end
                    end else if (r_state == StReadData) begin
                        if (w_tx_accept) begin
                            r_miso     <= bus.tx_data[TX_W-1];
                            r_tx_shift <= {bus.tx_data[TX_W-2:0], 1'b0};
                            r_tx_cnt   <= '0;
                            r_tx_busy  <= 1'b1;
                        end else if (r_tx_busy) begin
                            if (r_tx_cnt == TX_LAST) begin
                                r_miso         <= 1'b0;
                                r_tx_busy      <= 1'b0;
                                r_tx_done      <= 1'b1;
                                r_rd_addr_seen <= 1'b0;
                            end else begin
                                r_miso     <= r_tx_shift[TX_W-1];
                                r_tx_shift <= {r_tx_shift[TX_W-2:0], 1'b0};
                                r_tx_cnt   <= r_tx_cnt + 3'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= StIdle;
                    r_miso  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.miso     = r_miso;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: directed frame table plus randomized frames,
// checked cycle by cycle against a frame-level reference model.
module tb_spi_slave_ctrl;

    localparam int unsigned RX_W = 10;
    localparam int unsigned TX_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_ctrl_if #(.RX_W(RX_W), .TX_W(TX_W)) bus ();

    spi_slave_ctrl #(.RX_W(RX_W), .TX_W(TX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Upstream edge counter: 0 while deselected, counts cycles while selected
    logic [3:0] r_cnt = 4'd0;
    always_ff @(posedge clk) r_cnt <= bus.ss_n ? 4'd0 : r_cnt + 4'd1;
    assign bus.edge_cnt = r_cnt;

    typedef struct {
        logic       cmd;
        logic [9:0] payload;
        int         nbits;     // payload bits delivered before ss_n rises (10 = full)
        int         d;         // tx_valid pulse at posedge 12+d; -1 = none
        int         hold;      // extra selected cycles after the last payload bit
        logic [7:0] tx;
        int         rst_p;     // assert rst after the sample of posedge rst_p; -1 = none
        int         exp_pulses;
        logic [9:0] exp_rx;
        logic [7:0] exp_cap;   // miso seen at posedges 12+d .. 19+d
    } row_t;

    int   checks = 0;
    int   errors = 0;
    bit   m_flag;
    logic [9:0] m_rx;
    row_t rows[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t mk(input logic cmd, input logic [9:0] pl, input int nb,
                                input int d, input int hold, input logic [7:0] tx,
                                input int rp, input int ep, input logic [9:0] erx,
                                input logic [7:0] ecap);
        row_t r;
        r.cmd = cmd; r.payload = pl; r.nbits = nb; r.d = d; r.hold = hold; r.tx = tx;
        r.rst_p = rp; r.exp_pulses = ep; r.exp_rx = erx; r.exp_cap = ecap;
        return r;
    endfunction

    // Drive one frame, check every cycle against the model, then a short idle gap.
    task automatic run_frame(input row_t r, input bit use_exp, input string tag);
        int         kind;  // 0 write, 1 read-address, 2 read-data
        bit         complete;
        int         e;
        int         t;
        int         pulses;
        bit         done_rst;
        logic [7:0] cap;
        logic [9:0] old_rx;
        logic       em;
        int         g;
        complete = (r.nbits == int'(RX_W));
        kind     = !r.cmd ? 0 : (m_flag ? 2 : 1);
        e        = complete ? 12 + r.hold : 2 + r.nbits;
        t        = (kind == 2 && complete && r.d >= 0 && 12 + r.d < e) ? 12 + r.d : -1;
        old_rx   = m_rx;
        pulses   = 0;
        cap      = 8'h00;
        done_rst = 1'b0;
        for (int p = 0; p <= e && !done_rst; p++) begin
            bus.ss_n    = (p == e);
            bus.mosi    = (p == 1) ? r.cmd :
                          (p >= 2 && p <= 11) ? r.payload[11-p] : 1'($urandom_range(0, 1));
            bus.tx_data = (r.d >= 0 && p == 12 + r.d) ? r.tx : 8'($urandom);
            if (r.d >= 0 && p == 12 + r.d) begin
                bus.tx_valid = 1'b1;
            end else if (p < 12 || kind != 2 || (r.d >= 0 && p > 12 + r.d)) begin
                bus.tx_valid = 1'($urandom_range(0, 1));
            end else begin
                bus.tx_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            em = (t >= 0 && p >= t && p <= t + 7 && p < e) ? r.tx[7-(p-t)] : 1'b0;
            chk({tag, "_miso"}, 32'(bus.miso), 32'(em));
            chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'(complete && p == 11));
            chk({tag, "_rx_data"}, 32'(bus.rx_data),
                32'((complete && p >= 11) ? r.payload : old_rx));
            pulses += int'(bus.rx_valid);
            if (r.d >= 0 && p >= 12 + r.d && p <= 19 + r.d) cap[7-(p-12-r.d)] = bus.miso;
            if (p == r.rst_p) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, "_rst_miso"}, 32'(bus.miso), 32'(0));
                chk({tag, "_rst_rx_valid"}, 32'(bus.rx_valid), 32'(0));
                chk({tag, "_rst_rx_data"}, 32'(bus.rx_data), 32'(0));
                done_rst     = 1'b1;
                m_flag       = 1'b0;
                m_rx         = 10'h000;
                bus.ss_n     = 1'b1;
                bus.tx_valid = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end
        if (!done_rst) begin
            if (complete) m_rx = r.payload;
            if (kind == 1 && complete) m_flag = 1'b1;
            if (t >= 0 && e >= t + 8) m_flag = 1'b0;
        end
        if (use_exp) begin
            chk({tag, "_pulses"}, 32'(pulses), 32'(r.exp_pulses));
            chk({tag, "_final_rx"}, 32'(bus.rx_data), 32'(r.exp_rx));
            chk({tag, "_miso_byte"}, 32'(cap), 32'(r.exp_cap));
        end
        // Deselected gap: tx_valid must not reach miso in idle
        g = $urandom_range(1, 3);
        for (int i = 0; i < g; i++) begin
            bus.ss_n     = 1'b1;
            bus.tx_valid = 1'($urandom_range(0, 1));
            bus.tx_data  = 8'($urandom);
            bus.mosi     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk({tag, "_gap_miso"}, 32'(bus.miso), 32'(0));
            chk({tag, "_gap_rx_valid"}, 32'(bus.rx_valid), 32'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        rst          = 1'b1;
        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        m_flag       = 1'b0;
        m_rx         = 10'h000;

        //            cmd   payload  nb  d  hold tx     rst  pul exp_rx   exp_cap
        rows[0]  = mk(1'b0, 10'h0A5, 10, 0, 3,  8'hFF, -1,  1,  10'h0A5, 8'h00);
        rows[1]  = mk(1'b1, 10'h203, 10, 0, 2,  8'hFF, -1,  1,  10'h203, 8'h00);
        rows[2]  = mk(1'b1, 10'h35A, 10, 0, 10, 8'hC3, -1,  1,  10'h35A, 8'hC3);
        rows[3]  = mk(1'b1, 10'h2F0, 10, 0, 10, 8'hC3, -1,  1,  10'h2F0, 8'h00);
        rows[4]  = mk(1'b0, 10'h3FF, 6, -1, 0,  8'h00, -1,  0,  10'h2F0, 8'h00);
        rows[5]  = mk(1'b0, 10'h155, 10, -1, 1, 8'h00, -1,  1,  10'h155, 8'h00);
        rows[6]  = mk(1'b1, 10'h3C0, 10, 3, 14, 8'h5A, -1,  1,  10'h3C0, 8'h5A);
        rows[7]  = mk(1'b1, 10'h211, 10, -1, 0, 8'h00, -1,  1,  10'h211, 8'h00);
        rows[8]  = mk(1'b1, 10'h3E7, 10, 0, 4,  8'hFF, -1,  1,  10'h3E7, 8'hF0);
        rows[9]  = mk(1'b1, 10'h301, 10, 1, 12, 8'h81, -1,  1,  10'h301, 8'h81);
        rows[10] = mk(1'b1, 10'h200, 10, 0, 2,  8'h99, -1,  1,  10'h200, 8'h00);
        rows[11] = mk(1'b1, 10'h3A5, 10, 0, 12, 8'hA5, 14,  1,  10'h000, 8'hA0);
        rows[12] = mk(1'b1, 10'h2CC, 10, 0, 10, 8'hFF, -1,  1,  10'h2CC, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_miso", 32'(bus.miso), 32'(0));
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'(0));
        chk("reset_rx_data", 32'(bus.rx_data), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hFF;
            @(posedge clk);
            #1;
            chk("idle_tx_valid_miso", 32'(bus.miso), 32'(0));
        end
        bus.tx_valid = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_frame(rows[i], 1'b1, $sformatf("row%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            r.cmd     = 1'($urandom_range(0, 1));
            r.payload = 10'($urandom);
            r.nbits   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
            r.d       = int'($urandom_range(0, 5)) - 1;
            r.hold    = int'($urandom_range(0, 15));
            r.tx      = 8'($urandom);
            r.rst_p   = -1;
            r.exp_pulses = 0;
            r.exp_rx     = 10'h000;
            r.exp_cap    = 8'h00;
            run_frame(r, 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
